serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to register signed overflow on ovf; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic             diff_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] r_d;

  // Full-subtractor cell on the current LSBs plus the result shifted with the new bit at the MSB.
  always_comb begin
    diff_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    r_d        = WIDTH'({diff_bit_d, r_q} >> 1);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE always leaves after one cycle; a start seen on that exit edge is
        // taken directly so back-to-back results arrive every WIDTH+1 cycles.
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_SHIFT;
            a_q     <= A;
            b_q     <= B;
            r_q     <= '0;
            br_q    <= Bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= r_d;
            bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // br_q still holds the borrow into the MSB here.
            ovf_q   <= br_q ^ br_d;
`endif
          end else begin
            state_q <= S_SHIFT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a queue scoreboard of expected results.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             ovf;

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   done_cnt = 0;
  int   acc_cyc  = 0;
  exp_t sb_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    exp_t e;
`ifdef SERIAL_SUB_OVF_EN
    int s;
`endif
    e.d    = a - b - {{(WIDTH-1){1'b0}}, bin};
    e.bout = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, bin}));
`ifdef SERIAL_SUB_OVF_EN
    s      = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.ovf  = (s < -(2 ** (WIDTH - 1))) || (s > (2 ** (WIDTH - 1)) - 1);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input bit push, input bit hold);
    @(posedge clk); #1;
    A = a; B = b; Bin = bin; start = 1'b1;
    if (push) sb_q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    acc_cyc = cyc_cnt;
    if (!hold) start = 1'b0;
    A   = WIDTH'($urandom);
    B   = WIDTH'($urandom);
    Bin = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic collect(input string tag, input int acc, output int done_cyc);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    done_cyc = cyc_cnt;
    check({tag, "_latency"}, 32'(cyc_cnt - acc), 32'(WIDTH));
    check({tag, "_sb_has_entry"}, 32'(sb_q.size() != 0), 32'd1);
    e = '0;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check({tag, "_D"},    32'(D),    32'(e.d));
    check({tag, "_Bout"}, 32'(Bout), 32'(e.bout));
    check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
    check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dc;
    int dc2;
    int cnt_before;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D",    32'(D),    32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;

    start_op(8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
    collect("sub_05_03", acc_cyc, dc);

    start_op(8'h03, 8'h05, 1'b0, 1'b1, 1'b0);
    collect("sub_03_05", acc_cyc, dc);

    start_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    collect("sub_80_01", acc_cyc, dc);

    // Stray start during SHIFT cycle 3 must be ignored.
    cnt_before = done_cnt;
    start_op(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    A = 8'hAA; B = 8'h0F; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    collect("sub_00_00_b1", acc_cyc, dc);
    repeat (12) @(negedge clk);
    check("stray_D_held",    32'(D),    32'hFF);
    check("stray_Bout_held", 32'(Bout), 32'd1);
    check("stray_one_done",  32'(done_cnt - cnt_before), 32'd1);

    // Reset in SHIFT cycle 4 discards the operation.
    cnt_before = done_cnt;
    start_op(8'h55, 8'h11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_D",    32'(D),    32'd0);
    check("midrst_Bout", 32'(Bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - cnt_before), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    start_op(8'h55, 8'h11, 1'b0, 1'b1, 1'b0);
    collect("sub_55_11", acc_cyc, dc);

    // Back-to-back with start held high across both operations.
    @(posedge clk); #1;
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'h10, 8'h01, 1'b0));
    sb_q.push_back(model(8'h01, 8'h10, 1'b0));
    @(posedge clk); #1;
    acc_cyc = cyc_cnt;
    A = 8'h01; B = 8'h10; Bin = 1'b0;
    collect("b2b_first", acc_cyc, dc);
    start = 1'b0;
    collect("b2b_second", dc + 1, dc2);
    check("b2b_spacing", 32'(dc2 - dc), 32'(WIDTH + 1));
    repeat (12) @(negedge clk);
    check("b2b_no_third", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
